// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, prefix bytes, HID codes and set-2 translation for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_ESC   = 8'h29;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;

    // Scan-code set 2 to HID usage for the keys the game logic cares about.
    function automatic logic [7:0] xlate(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = HID_NONE;
        if (ext) begin
            case (code)
                8'h6B:   hid = HID_LEFT;
                8'h74:   hid = HID_RIGHT;
                8'h75:   hid = HID_UP;
                8'h72:   hid = HID_DOWN;
                default: hid = HID_NONE;
            endcase
        end else begin
            case (code)
                8'h1C:   hid = HID_A;
                8'h23:   hid = HID_D;
                8'h1D:   hid = HID_W;
                8'h1B:   hid = HID_S;
                8'h29:   hid = HID_SPACE;
                8'h5A:   hid = HID_ENTER;
                8'h76:   hid = HID_ESC;
                default: hid = HID_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, falling-edge detect, 11-bit frame FSM and timeout
// Ports: Clk, Reset_n (async active-low); ps2_clk, ps2_data raw pins;
//        rx_byte (good byte), rx_strobe (1-cycle, byte valid), rx_err (1-cycle parity/stop/timeout error).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,   // must be >= 2
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   data_cur;
    logic                   fall;

    frame_state_t state, state_n;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic          good;
    logic          bad;

    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign data_cur = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_cur;
    // A fall arriving in the same cycle takes precedence over the timeout.
    assign timeout  = (state != IDLE) && !fall && (cnt == CNT_LAST);

    // Synchronisers reset to the idle-high bus level so release never fakes an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_cur;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        good    = 1'b0;
        bad     = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    if (!data_cur) state_n = DATA;
                DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (data_cur && (^{shreg, par_bit})) good = 1'b1;
                    else                                 bad  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            bad     = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            cnt       <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_strobe <= good;
            rx_err    <= bad;
            if (good) rx_byte <= shreg;

            if (fall || state == IDLE || timeout) cnt <= '0;
            else                                  cnt <= cnt + CW'(1);

            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        shreg   <= {data_cur, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit <= data_cur;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 keyboard receiver producing an HID-style held keycode
// Ports: Clk, Reset_n (async active-low); ps2_clk, ps2_data raw pins;
//        keycode/key_valid (held HID key, pulse on change), scancode/scan_strobe (last good byte),
//        frame_err (1-cycle pulse on parity, stop-bit or timeout error).
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic [7:0] scancode,
    output logic       scan_strobe,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [7:0] hid;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_strobe(rx_strobe),
        .rx_err   (rx_err)
    );

    assign frame_err = rx_err;
    assign hid       = xlate(ext, scancode);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scancode    <= '0;
            scan_strobe <= 1'b0;
        end else begin
            scan_strobe <= rx_strobe;
            if (rx_strobe) scancode <= rx_byte;
        end
    end

    // Decode works on the registered scancode during its strobe cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            keycode   <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_strobe) begin
                if (scancode == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (scancode == PS2_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!brk && hid != HID_NONE) begin
                        keycode   <= hid;
                        key_valid <= (hid != keycode);
                    end else if (brk && hid != HID_NONE && hid == keycode) begin
                        // Only releasing the key currently shown clears it: last make wins.
                        keycode   <= HID_NONE;
                        key_valid <= 1'b1;
                    end
                end
            end
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - scoreboard testbench for ps2_keycode_rx
module tb_ps2_keycode_rx;

    localparam int SYNC = 2;
    localparam int TMO  = 1000;
    localparam int H    = 20;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic [7:0] scancode;
    logic       scan_strobe;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int fall_cyc = 0;
    int err_pending = 0;
    bit lat_checked = 0;
    logic [7:0] exp_scan[$];
    logic [7:0] exp_key[$];

    ps2_keycode_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .key_valid  (key_valid),
        .scancode   (scancode),
        .scan_strobe(scan_strobe),
        .frame_err  (frame_err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (scan_strobe) begin
                if (exp_scan.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scan_unexpected: got %0h, expected no strobe", scancode);
                end else begin
                    check("scancode", scancode, exp_scan.pop_front());
                end
                if (!lat_checked) begin
                    lat_checked = 1;
                    check("stop_to_strobe_latency", cyc - stop_cyc, SYNC + 2);
                end
            end
            if (key_valid) begin
                if (exp_key.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL key_unexpected: got %0h, expected no key_valid", keycode);
                end else begin
                    check("keycode", keycode, exp_key.pop_front());
                end
            end
            if (frame_err) begin
                if (err_pending == 0) begin
                    checks++; errors++;
                    $display("FAIL err_unexpected: got frame_err, expected none");
                end else begin
                    checks++;
                    err_pending--;
                end
            end
        end
    end

    // Bit order on the wire: start(0), data LSB first, odd parity, stop(1).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge Clk);
            ps2_clk = 1'b0;
            fall_cyc = cyc;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge Clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge Clk);
    endtask

    task automatic good(input logic [7:0] b);
        exp_scan.push_back(b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic good_key(input logic [7:0] b, input logic [7:0] k);
        exp_key.push_back(k);
        good(b);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        check("reset_keycode", keycode, 0);
        check("reset_scancode", scancode, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_scan_strobe", scan_strobe, 0);
        check("reset_frame_err", frame_err, 0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        // Single make, then break sequence.
        good_key(8'h1C, 8'h04);
        check("held_A", keycode, 8'h04);
        good(8'hF0);
        good_key(8'h1C, 8'h00);
        check("released_A", keycode, 8'h00);

        // Extended arrows; bare 74 translates to nothing.
        good(8'hE0); good_key(8'h74, 8'h4F);
        check("held_right", keycode, 8'h4F);
        good(8'hE0); good(8'hF0); good_key(8'h74, 8'h00);
        good(8'h74);
        check("bare_74", keycode, 8'h00);

        // Last make wins; typematic repeat gives no pulse.
        good_key(8'h1C, 8'h04);
        good_key(8'h23, 8'h07);
        good(8'h23);
        good(8'hF0); good(8'h1C);
        check("A_release_keeps_D", keycode, 8'h07);
        good(8'hF0); good_key(8'h23, 8'h00);

        // Parity error, then a frame error clearing a pending E0.
        good_key(8'h1D, 8'h1A);
        err_pending++;
        send_frame(8'h23, 1'b1, 1'b0, 11);
        check("bad_par_scancode", scancode, 8'h1D);
        check("bad_par_keycode", keycode, 8'h1A);
        good_key(8'h1B, 8'h16);
        good(8'hE0);
        err_pending++;
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        good(8'h75);
        check("ext_cleared_by_err", keycode, 8'h16);
        good(8'hF0); good_key(8'h1B, 8'h00);

        // Timeout after a partial frame (5 falls).
        err_pending++;
        send_frame(8'h55, 1'b0, 1'b0, 5);
        n = 0;
        while (!frame_err && n < 3 * TMO) begin
            @(negedge Clk);
            n++;
        end
        check("timeout_seen", frame_err, 1);
        check("timeout_delay", cyc - fall_cyc, TMO + SYNC + 1);
        repeat (5) @(negedge Clk);
        good_key(8'h29, 8'h2C);

        // Reset in the middle of a frame.
        send_frame(8'h1D, 1'b0, 1'b0, 5);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("rst_keycode", keycode, 0);
        check("rst_scancode", scancode, 0);
        check("rst_flags", {key_valid, scan_strobe, frame_err}, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        good_key(8'h1D, 8'h1A);
        check("after_reset_W", keycode, 8'h1A);

        repeat (20) @(negedge Clk);
        check("scan_q_left", exp_scan.size(), 0);
        check("key_q_left", exp_key.size(), 0);
        check("err_left", err_pending, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Hardware PS/2 keyboard receiver that produces the same 8-bit USB-HID-style `keycode` that jumplogic and color_mapper consume today from the Nios keycode PIO.
- Receives device-clocked 11-bit PS/2 frames and checks them.
- Tracks make/break (F0) and extended (E0) prefixes, then translates a fixed key set into HID usage codes.
- Sits beside the SoC; a top-level mux selects the PIO or this block as the keycode source.

Parameters:
- SYNC_STAGES, 2, flops in each ps2_clk/ps2_data synchroniser.
- TIMEOUT_CYCLES, 100000, Clk cycles (2 ms at 50 MHz) without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- Clk  input  1  system clock, MAX10_CLK1_50.
- Reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
- ps2_data  input  1  raw PS/2 data from the pin, asynchronous.
- keycode  output  8  HID usage of the held translated key; 0x00 when none is held.
- key_valid  output  1  one-cycle pulse whenever keycode changes value.
- scancode  output  8  last correctly received raw byte.
- scan_strobe  output  1  one-cycle pulse when scancode is loaded.
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (async assert, sync release): all outputs 0, both FSMs in IDLE, prefix flags cleared, timeout counter 0.
- Inputs pass through SYNC_STAGES flops. Edge detect: registered previous sync clock; fall = prev & ~cur.
- Frame FSM (advances only on fall):
  - IDLE: data==0 -> DATA, bit count 0. data==1 is ignored (glitch) and the FSM stays in IDLE.
  - DATA: shift LSB-first into an 8-bit register; after the 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: good frame = stop==1 and odd parity (XOR of 8 data bits and parity bit == 1).
    - Good: scancode <= byte, scan_strobe=1 next cycle.
    - Bad: frame_err=1, scancode is not updated.
    - Either way -> IDLE.
- Timeout:
  - Counter clears on every fall and whenever the FSM is in IDLE.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE, frame_err pulse, partial byte dropped.
- Decode (acts in the cycle scan_strobe is high; keycode/key_valid register one cycle later):
  - Byte E0 sets ext; byte F0 sets brk. Neither changes keycode.
  - Any other byte: look up hid = xlate(ext, byte), then clear ext and brk.
    - Make (brk=0), hid!=0: keycode<=hid, key_valid pulses if the value changed.
    - Break (brk=1), hid==keycode: keycode<=0, key_valid pulses.
    - Break of a different key: no change.
    - hid==0 (untranslated byte): no change.
- Typematic repeat of the held make produces no key_valid, since the value does not change.
- frame_err also clears ext and brk.
- Translation table (set 2 -> HID):
  - Non-extended: 1C->04 (A), 23->07 (D), 1D->1A (W), 1B->16 (S), 29->2C (space), 5A->28 (Enter), 76->29 (Esc).
  - Extended (E0 prefix): 6B->50 (left), 74->4F (right), 75->52 (up), 72->51 (down).
  - Everything else -> 00.
- Last-make-wins: pressing D while A is held gives 07; releasing A then leaves 07. Releasing D gives 00.
- Latency: the stop-bit pin edge reaches scan_strobe in SYNC_STAGES+2 cycles; keycode follows 1 cycle later.
- Simultaneous events: a fall in the same cycle the timeout would fire wins; the timeout does not fire.
- Reset mid-frame discards everything; the first frame after release must start from IDLE.

Decomposition:
- Package ps2_pkg:
  - frame-state enum (IDLE, DATA, PARITY, STOP).
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - HID constants.
  - function xlate(ext, byte) returning the 8-bit HID code.
- One sub-module, ps2_frame_rx: sync, edge detect, frame FSM, timeout. It outputs byte/strobe/err.
- The top holds the prefix flags, translation and keycode register.

Test Plan:
- Frame 1C, odd parity ok, 60 us bit period -> scancode=1C, scan_strobe x1, keycode=04, key_valid x1.
- Sequence 1C, F0, 1C -> keycode 04 then 00; two key_valid pulses total; no pulse on F0.
- Sequence E0 74, then E0 F0 74 -> keycode 4F then 00; byte 74 without E0 afterwards gives 00, no change.
- Frame 23 with parity bit inverted -> frame_err x1, scancode unchanged, keycode unchanged; next good frame is accepted.
- 5 bits then ps2_clk held high for TIMEOUT_CYCLES -> frame_err at exactly TIMEOUT_CYCLES after the last fall; then frame 29 gives keycode=2C.
- Reset_n low mid-frame (bit 4) -> all outputs 0 immediately; a following full frame 1D gives keycode=1A.
